// File: rtl/jtoutrun_rdpkg.sv
// Shared definitions for the road-engine ROM slot: FSM states, client ids and
// default SDRAM base offsets for the two road layers.
package jtoutrun_rdpkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_DST = 2'd2,
    WAIT_RDY = 2'd3
  } rd_state_t;

  localparam logic RD0 = 1'b0;
  localparam logic RD1 = 1'b1;

  localparam logic [21:0] DEF_OFFSET0 = 22'h0;
  localparam logic [21:0] DEF_OFFSET1 = 22'h4000;

endpackage

// File: rtl/jtoutrun_rdrom_entry.sv
// One-word cache entry for a road-layer ROM client: tag/data/valid storage,
// hit compare and registered ok/data. Contents exported with JTOUTRUN_RDROM_PREFETCH_EN.
module jtoutrun_rdrom_entry #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] wtag,
  input  logic [15:0]   wdata,
  input  logic          wvalid,
  output logic          hit,
`ifdef JTOUTRUN_RDROM_PREFETCH_EN
  output logic [AW-1:0] tag,
  output logic [15:0]   mem,
  output logic          valid,
`endif
  output logic          ok,
  output logic [15:0]   dout
);

`ifndef JTOUTRUN_RDROM_PREFETCH_EN
  logic [AW-1:0] tag;
  logic [15:0]   mem;
  logic          valid;
`endif

  assign hit = cs && valid && (tag == addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      tag   <= '0;
      mem   <= '0;
      valid <= 1'b0;
      ok    <= 1'b0;
      dout  <= '0;
    end else begin
      if (we) begin
        tag   <= wtag;
        mem   <= wdata;
        valid <= wvalid;
      end
      ok <= hit;
      if (hit) dout <= mem;
    end
  end

endmodule

// File: rtl/jtoutrun_rdrom_slot.sv
// Serves the two road-layer ROM fetchers from one SDRAM slot (req/ack/dst/rdy)
// with a one-word cache per client. Optional next-word prefetch: JTOUTRUN_RDROM_PREFETCH_EN.
module jtoutrun_rdrom_slot
  import jtoutrun_rdpkg::*;
#(
  parameter int             AW      = 14,
  parameter int             SDW     = 22,
  parameter logic [SDW-1:0] OFFSET0 = SDW'(DEF_OFFSET0),
  parameter logic [SDW-1:0] OFFSET1 = SDW'(DEF_OFFSET1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [AW-1:0]  rom0_addr,
  input  logic           rom0_cs,
  output logic [15:0]    rom0_data,
  output logic           rom0_ok,
  input  logic [AW-1:0]  rom1_addr,
  input  logic           rom1_cs,
  output logic [15:0]    rom1_data,
  output logic           rom1_ok,
  output logic [SDW-1:0] sdram_addr,
  output logic           sdram_req,
  input  logic           sdram_ack,
  input  logic           sdram_dst,
  input  logic           sdram_rdy,
  input  logic [15:0]    sdram_din
);

  rd_state_t      state;
  logic           cur_id, last;
  logic [AW-1:0]  cur_tag;
  logic [AW-1:0]  addr_a [2];
  logic           cs_a   [2];
  logic           hit_a  [2];
  logic           ok_a   [2];
  logic [15:0]    dout_a [2];
  logic           miss0, miss1, pick, fill_we;
  logic [AW-1:0]  pick_addr;
  logic [SDW-1:0] pick_base;

  assign addr_a[0] = rom0_addr;
  assign addr_a[1] = rom1_addr;
  assign cs_a[0]   = rom0_cs;
  assign cs_a[1]   = rom1_cs;

  assign miss0     = rom0_cs && !hit_a[0];
  assign miss1     = rom1_cs && !hit_a[1];
  assign pick      = (miss0 && miss1) ? ~last : miss1;
  assign pick_addr = pick ? rom1_addr : rom0_addr;
  assign pick_base = (pick ? OFFSET1 : OFFSET0) + SDW'(pick_addr);
  assign fill_we   = (state == WAIT_DST) && sdram_dst;

`ifdef JTOUTRUN_RDROM_PREFETCH_EN
  logic           cur_pf, pf_pend, pf_id, fill_done;
  logic [AW-1:0]  pf_tag;
  logic [SDW-1:0] pf_base;

  assign fill_done = ((state == WAIT_DST) && sdram_dst && sdram_rdy) ||
                     ((state == WAIT_RDY) && sdram_rdy);
  assign pf_base   = (pf_id ? OFFSET1 : OFFSET0) + SDW'(pf_tag);
`endif

  for (genvar i = 0; i < 2; i++) begin : g_cli
    logic mine;
    assign mine = fill_we && (cur_id == 1'(i));
`ifdef JTOUTRUN_RDROM_PREFETCH_EN
    logic          hit_d, hit_p, ok_d, ok_p, valid_d, valid_p, swap, dwe, pwe;
    logic [AW-1:0] tag_d, tag_p;
    logic [15:0]   mem_d, mem_p, dout_d, dout_p;

    // A prefetch-entry hit swaps both entries unless a fill lands this cycle.
    assign swap = hit_p && !mine;
    assign dwe  = (mine && !cur_pf) || swap;
    assign pwe  = (mine &&  cur_pf) || swap;

    jtoutrun_rdrom_entry #(.AW(AW)) u_dem (
      .clk(clk), .rst(rst), .addr(addr_a[i]), .cs(cs_a[i]),
      .we(dwe), .wtag(swap ? tag_p : cur_tag), .wdata(swap ? mem_p : sdram_din),
      .wvalid(swap ? valid_p : 1'b1), .hit(hit_d),
      .tag(tag_d), .mem(mem_d), .valid(valid_d), .ok(ok_d), .dout(dout_d)
    );
    jtoutrun_rdrom_entry #(.AW(AW)) u_pre (
      .clk(clk), .rst(rst), .addr(addr_a[i]), .cs(cs_a[i]),
      .we(pwe), .wtag(swap ? tag_d : cur_tag), .wdata(swap ? mem_d : sdram_din),
      .wvalid(swap ? valid_d : 1'b1), .hit(hit_p),
      .tag(tag_p), .mem(mem_p), .valid(valid_p), .ok(ok_p), .dout(dout_p)
    );

    assign hit_a[i]  = hit_d || hit_p;
    assign ok_a[i]   = ok_d || ok_p;
    assign dout_a[i] = ok_p ? dout_p : dout_d;
`else
    jtoutrun_rdrom_entry #(.AW(AW)) u_dem (
      .clk(clk), .rst(rst), .addr(addr_a[i]), .cs(cs_a[i]),
      .we(mine), .wtag(cur_tag), .wdata(sdram_din), .wvalid(1'b1),
      .hit(hit_a[i]), .ok(ok_a[i]), .dout(dout_a[i])
    );
`endif
  end

  assign rom0_ok   = ok_a[0];
  assign rom1_ok   = ok_a[1];
  assign rom0_data = dout_a[0];
  assign rom1_data = dout_a[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      cur_id     <= RD0;
      cur_tag    <= '0;
      last       <= RD1;
`ifdef JTOUTRUN_RDROM_PREFETCH_EN
      cur_pf     <= 1'b0;
      pf_pend    <= 1'b0;
      pf_id      <= RD0;
      pf_tag     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (miss0 || miss1) begin
            cur_id     <= pick;
            cur_tag    <= pick_addr;
            sdram_addr <= pick_base;
            sdram_req  <= 1'b1;
            state      <= WAIT_ACK;
            // Round-robin pointer only advances on contested grants.
            if (miss0 && miss1) last <= pick;
`ifdef JTOUTRUN_RDROM_PREFETCH_EN
            cur_pf     <= 1'b0;
            pf_pend    <= 1'b0;
          end else if (pf_pend) begin
            cur_id     <= pf_id;
            cur_tag    <= pf_tag;
            sdram_addr <= pf_base;
            sdram_req  <= 1'b1;
            cur_pf     <= 1'b1;
            pf_pend    <= 1'b0;
            state      <= WAIT_ACK;
`endif
          end
        end
        WAIT_ACK: if (sdram_ack) begin
          sdram_req <= 1'b0;
          state     <= WAIT_DST;
        end
        WAIT_DST: if (sdram_dst) state <= sdram_rdy ? IDLE : WAIT_RDY;
        WAIT_RDY: if (sdram_rdy) state <= IDLE;
        default:  state <= IDLE;
      endcase
`ifdef JTOUTRUN_RDROM_PREFETCH_EN
      if (fill_done && !cur_pf) begin
        pf_pend <= 1'b1;
        pf_id   <= cur_id;
        pf_tag  <= cur_tag + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_jtoutrun_rdrom_slot.sv
// Directed bench for jtoutrun_rdrom_slot: the bench acts as the SDRAM side and keeps
// a queue of expected requests (address + data to return) pushed as stimulus is driven.
module tb_jtoutrun_rdrom_slot;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] rom0_addr = '0, rom1_addr = '0;
  logic        rom0_cs = 1'b0, rom1_cs = 1'b0;
  logic [15:0] rom0_data, rom1_data;
  logic        rom0_ok, rom1_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack = 1'b0, sdram_dst = 1'b0, sdram_rdy = 1'b0;
  logic [15:0] sdram_din = '0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [21:0] addr;
    logic [15:0] din;
  } req_t;
  req_t req_q[$];

  jtoutrun_rdrom_slot #(.AW(14), .SDW(22), .OFFSET0(22'h0), .OFFSET1(22'h4000)) dut (
    .clk(clk), .rst(rst),
    .rom0_addr(rom0_addr), .rom0_cs(rom0_cs), .rom0_data(rom0_data), .rom0_ok(rom0_ok),
    .rom1_addr(rom1_addr), .rom1_cs(rom1_cs), .rom1_data(rom1_data), .rom1_ok(rom1_ok),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sdram_dst(sdram_dst), .sdram_rdy(sdram_rdy), .sdram_din(sdram_din)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [21:0] a, input logic [15:0] d);
    req_t r;
    r.addr = a;
    r.din  = d;
    req_q.push_back(r);
  endtask

  task automatic wait_req();
    int n = 0;
    while (sdram_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("req_seen", 32'(sdram_req), 32'd1);
  endtask

  // Serve the oldest expected request; rom0 addr/cs are re-driven when the
  // DUT reaches WAIT_DST so mid-fill changes can be exercised.
  task automatic serve(input bit same_cycle, input logic [13:0] a0_at_dst, input logic cs0_at_dst);
    req_t r;
    wait_req();
    r.addr = '0;
    r.din  = '0;
    if (req_q.size() != 0) r = req_q.pop_front();
    check("sdram_addr", 32'(sdram_addr), 32'(r.addr));
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("req_dropped", 32'(sdram_req), 32'd0);
    rom0_addr = a0_at_dst;
    rom0_cs   = cs0_at_dst;
    sdram_dst = 1'b1;
    sdram_din = r.din;
    sdram_rdy = same_cycle;
    tick();
    sdram_dst = 1'b0;
    sdram_din = '0;
    if (!same_cycle) begin
      sdram_rdy = 1'b1;
      tick();
    end
    sdram_rdy = 1'b0;
  endtask

  task automatic wait_ok(input bit cl, input logic [15:0] d);
    int n = 0;
    while ((cl ? rom1_ok : rom0_ok) !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check(cl ? "rom1_ok" : "rom0_ok", 32'(cl ? rom1_ok : rom0_ok), 32'd1);
    check(cl ? "rom1_data" : "rom0_data", 32'(cl ? rom1_data : rom0_data), 32'(d));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_req",   32'(sdram_req),  32'd0);
    check("rst_addr",  32'(sdram_addr), 32'd0);
    check("rst_ok0",   32'(rom0_ok),    32'd0);
    check("rst_ok1",   32'(rom1_ok),    32'd0);
    check("rst_data0", 32'(rom0_data),  32'd0);
    check("rst_data1", 32'(rom1_data),  32'd0);

`ifdef JTOUTRUN_RDROM_PREFETCH_EN
    rom0_addr = 14'h3FFF;
    rom0_cs   = 1'b1;
    push(22'h003FFF, 16'hAAAA);
    push(22'h000000, 16'hBBBB);
    serve(1'b0, 14'h3FFF, 1'b1);
    wait_ok(1'b0, 16'hAAAA);
    serve(1'b0, 14'h3FFF, 1'b1);
    tick();
    rom0_addr = 14'h0000;
    tick();
    check("pf_ok",      32'(rom0_ok),   32'd1);
    check("pf_data",    32'(rom0_data), 32'hBBBB);
    check("pf_no_req",  32'(sdram_req), 32'd0);
    tick();
    check("pf_ok_hold", 32'(rom0_ok),   32'd1);
    rom0_addr = 14'h3FFF;
    tick();
    check("pf_back_ok",   32'(rom0_ok),   32'd1);
    check("pf_back_data", 32'(rom0_data), 32'hAAAA);
    check("pf_back_req",  32'(sdram_req), 32'd0);
`else
    // Single miss with one-clock spacing between ack, dst and rdy
    rom0_addr = 14'h0123;
    rom0_cs   = 1'b1;
    push(22'h000123, 16'hBEEF);
    serve(1'b0, 14'h0123, 1'b1);
    wait_ok(1'b0, 16'hBEEF);

    // Simultaneous misses after reset: rom0 first, then rom1
    do_reset();
    rom0_addr = 14'h0010;
    rom1_addr = 14'h0020;
    rom0_cs   = 1'b1;
    rom1_cs   = 1'b1;
    push(22'h000010, 16'h1010);
    push(22'h004020, 16'h2020);
    serve(1'b0, 14'h0010, 1'b1);
    serve(1'b0, 14'h0010, 1'b1);
    wait_ok(1'b0, 16'h1010);
    wait_ok(1'b1, 16'h2020);

    // Hit after cs toggle: no SDRAM traffic
    rom1_cs = 1'b0;
    tick();
    check("hit_cs_off_ok", 32'(rom1_ok), 32'd0);
    rom1_cs = 1'b1;
    tick();
    check("hit_ok",     32'(rom1_ok),   32'd1);
    check("hit_data",   32'(rom1_data), 32'h2020);
    check("hit_no_req", 32'(sdram_req), 32'd0);

    // Next contested miss goes to rom1 first
    rom0_addr = 14'h0011;
    rom1_addr = 14'h0021;
    push(22'h004021, 16'h2121);
    push(22'h000011, 16'h1111);
    serve(1'b0, 14'h0011, 1'b1);
    serve(1'b0, 14'h0011, 1'b1);
    wait_ok(1'b1, 16'h2121);
    wait_ok(1'b0, 16'h1111);

    // Zero-wait ack with dst+rdy together: ok exactly 4 clocks after cs/addr
    rom1_addr = 14'h0300;
    push(22'h004300, 16'h3030);
    serve(1'b1, 14'h0011, 1'b1);
    check("lat_ok_early", 32'(rom1_ok), 32'd0);
    tick();
    check("lat_ok",   32'(rom1_ok),   32'd1);
    check("lat_data", 32'(rom1_data), 32'h3030);

    // Address change while in WAIT_DST
    rom1_cs   = 1'b0;
    rom0_addr = 14'h0100;
    push(22'h000100, 16'h0100);
    push(22'h000101, 16'h0101);
    serve(1'b0, 14'h0101, 1'b1);
    check("chg_ok_low", 32'(rom0_ok), 32'd0);
    serve(1'b0, 14'h0101, 1'b1);
    wait_ok(1'b0, 16'h0101);

    // cs falling mid-fill still writes the entry
    rom0_addr = 14'h0200;
    push(22'h000200, 16'h0200);
    serve(1'b0, 14'h0200, 1'b0);
    check("csdrop_ok_low", 32'(rom0_ok), 32'd0);
    rom0_cs = 1'b1;
    tick();
    check("csdrop_hit",    32'(rom0_ok),   32'd1);
    check("csdrop_data",   32'(rom0_data), 32'h0200);
    check("csdrop_no_req", 32'(sdram_req), 32'd0);

    // Reset in WAIT_ACK, then a stale strobe
    rom0_cs   = 1'b0;
    rom1_addr = 14'h0555;
    rom1_cs   = 1'b1;
    push(22'h004555, 16'hDEAD);
    wait_req();
    begin
      req_t r;
      r = req_q.pop_front();
      check("rst_fill_addr", 32'(sdram_addr), 32'(r.addr));
    end
    rst     = 1'b1;
    rom1_cs = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_req", 32'(sdram_req), 32'd0);
    check("midrst_ok0", 32'(rom0_ok),   32'd0);
    check("midrst_ok1", 32'(rom1_ok),   32'd0);
    sdram_dst = 1'b1;
    sdram_din = 16'hDEAD;
    tick();
    sdram_dst = 1'b0;
    sdram_din = '0;
    rom1_cs   = 1'b1;
    tick();
    check("stale_ok1", 32'(rom1_ok),   32'd0);
    check("stale_req", 32'(sdram_req), 32'd1);
    push(22'h004555, 16'h5555);
    serve(1'b0, 14'h0200, 1'b0);
    wait_ok(1'b1, 16'h5555);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtoutrun_rdrom_slot.md
Name: jtoutrun_rdrom_slot

Overview:
- Responder end of the road-engine ROM interface. It serves the two road-layer ROM fetchers (rom0/rom1 addr/cs/ok) from a single SDRAM slot.
- Uses the req/ack/dst/rdy handshake and keeps a one-word cache per client.
- Sits between the road renderer and the SDRAM controller in the OutRun video subsystem. Both road layers fetch one 16-bit word every 8 pixels, so a single arbitrated slot is sufficient.

Parameters:
- AW, 14, client word-address width.
- SDW, 22, SDRAM word-address width.
- OFFSET0, 22'h0, SDRAM base added to rom0_addr.
- OFFSET1, 22'h4000, SDRAM base added to rom1_addr.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- rom0_addr  in  AW  layer-0 word address
- rom0_cs  in  1  layer-0 request
- rom0_data  out  16  layer-0 data
- rom0_ok  out  1  rom0_data valid for current rom0_addr
- rom1_addr  in  AW  layer-1 word address
- rom1_cs  in  1  layer-1 request
- rom1_data  out  16  layer-1 data
- rom1_ok  out  1  rom1_data valid for current rom1_addr
- sdram_addr  out  SDW  SDRAM word address
- sdram_req  out  1  SDRAM request, held until sdram_ack
- sdram_ack  in  1  request accepted
- sdram_dst  in  1  data strobe; sdram_din valid
- sdram_rdy  in  1  burst complete
- sdram_din  in  16  SDRAM read data

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active high. On reset:
  - all outputs go to 0;
  - cache valid bits clear;
  - the FSM returns to IDLE.
- Per-client cache entry: tag[AW-1:0], data[15:0], valid.
- Hit: cs & valid & tag==addr. The registered ok and data follow one clock after the hit condition. ok drops one clock after addr changes to a non-matching value or cs falls.
- Miss: cs & !hit, and no fill for that client already in flight.
- FSM states:
  - IDLE: choose a client with a miss; latch the client id and address; set sdram_addr = OFFSETn + zero-extended addr (mod 2^SDW); assert sdram_req; go to WAIT_ACK.
  - WAIT_ACK: hold sdram_req and sdram_addr stable. On sdram_ack, drop sdram_req and go to WAIT_DST.
  - WAIT_DST: on sdram_dst, write sdram_din into the latched client's entry with the latched tag and set valid; go to WAIT_RDY.
  - WAIT_RDY: on sdram_rdy, go to IDLE. If dst and rdy arrive in the same cycle, IDLE is entered directly.
- Arbitration: round-robin. When both clients miss in the same IDLE cycle, the client not served last wins. After reset, client 0 wins.
- Address change during a fill: the fill completes with the latched tag. ok stays low unless the new addr equals that tag. A new miss is serviced afterwards.
- cs falling during a fill: the fill completes and the entry is written. No abort is issued to the SDRAM.
- Fill complete and new hit: the data written in cycle N may produce ok in cycle N+1. Do not wait an extra cycle.
- Throughput: at most one outstanding SDRAM request. Minimum miss latency from cs to ok is 4 clocks with zero-wait ack/dst.
- Spurious strobes: sdram_dst or sdram_rdy seen in IDLE is ignored. A reset asserted mid-fill discards the fill.

Optional Feature:
- Macro: JTOUTRUN_RDROM_PREFETCH_EN.
- With it defined:
  - Each client gains a second entry holding addr+1; AW wraps so that 3FFF+1 becomes 0000.
  - After a demand fill completes and no demand miss is pending, the FSM issues a prefetch for tag+1 of the client just served.
  - A hit in the prefetch entry behaves as a normal hit and swaps the two entries.
  - Demand misses always win over prefetches. A prefetch already in flight completes normally.
- Without it: single entry per client, demand fetches only.

Decomposition:
- Shared package jtoutrun_rdpkg holds:
  - FSM state encoding: IDLE=0, WAIT_ACK=1, WAIT_DST=2, WAIT_RDY=3;
  - client id constants: RD0=0, RD1=1;
  - default OFFSET0 and OFFSET1.
- One natural sub-module, jtoutrun_rdrom_entry: the per-client cache entry with its tag/valid/data registers, hit compare and registered ok/data output. It is instantiated twice, or four times with prefetch.

Test Plan:
- Reset then rom0_cs=1, rom0_addr=0x0123, with ack/dst/rdy each one clock after the previous → sdram_addr=0x000123, then rom0_ok=1 with rom0_data equal to the sdram_din value (0xBEEF).
- Both clients miss in the same cycle (rom0_addr=0x0010, rom1_addr=0x0020) → first request goes to 0x000010, second to 0x004020; both ok after their fills; next simultaneous miss serves rom1 first.
- Hit: after a filled rom1_addr=0x0020, toggle rom1_cs off then on with the same addr → rom1_ok=1 one clock later with no sdram_req.
- Change rom0_addr from 0x0100 to 0x0101 while in WAIT_DST → rom0_ok stays 0 after the 0x0100 fill; a second request to 0x000101 follows.
- Assert rst while in WAIT_ACK → next clock sdram_req=0, both ok=0; a stale sdram_dst afterwards does not set any valid.
- With JTOUTRUN_RDROM_PREFETCH_EN: fill rom0 0x3FFF → prefetch request to 0x000000; then rom0_addr=0x0000 → ok one clock later with no new request.
